codec_cfg_scheduler: RTL and testbench

Sequences all register writes to the WM8731 audio codec over its shared 2-wire (I2C) control bus. On `i_start` it issues the fixed boot-initialisation word list. It then arbitrates run-time write requests (volume, sample-rate, mute changes from the player/recorder logic) onto the same bus, one frame at a time. It owns the bit-level write engine and drives the tri-state pins (`o_sclk`, `o_sdat`, `o_oen`) at the top level.

---
 rtl/codec_cfg_pkg.sv | 49 ++++
 rtl/i2c_write_engine.sv | 173 +++++++++++++++++
 rtl/codec_cfg_scheduler.sv | 108 ++++++++++
 tb/tb_codec_cfg_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the WM8731 control-bus scheduler and its write engine.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_RUN_ISSUE,
    S_RUN_WAIT
  } sched_state_t;

  typedef enum logic [3:0] {
    E_IDLE,
    E_LOAD,
    E_START,
    E_BIT_LO,
    E_BIT_HI,
    E_STOP0,
    E_STOP1,
    E_STOP2,
    E_BUF
  } eng_state_t;

  // Codec address 7'h1A shifted left with the write bit appended.
  localparam logic [7:0] WRITE_BYTE = 8'h34;

  // Each byte on the wire occupies 8 data slots followed by one ACK slot.
  localparam logic [3:0] ACK_SLOT = 4'd8;

  localparam int INIT_WORDS = 7;

  // Boot words as {reg_addr[6:0], reg_data[8:0]}.
  localparam logic [15:0] INIT_ROM [INIT_WORDS] = '{
    {7'h00, 9'h017},  // left line in: 0 dB, unmuted
    {7'h01, 9'h017},  // right line in: 0 dB, unmuted
    {7'h04, 9'h012},  // analog path: DAC selected, line input to ADC
    {7'h05, 9'h000},  // digital path: no de-emphasis, DAC soft mute off
    {7'h06, 9'h000},  // power down: everything powered
    {7'h07, 9'h042},  // interface format: master, I2S, 16 bit
    {7'h08, 9'h000}   // sampling control: normal mode, 48 kHz
  };

  // Builds the 24-bit frame the engine shifts out: address byte then register word.
  function automatic logic [23:0] frame_word(input logic [7:0] addr_byte,
                                             input logic [15:0] payload);
    return {addr_byte, payload};
  endfunction

endpackage

// File: rtl/i2c_write_engine.sv
// Bit-level 2-wire write engine: START, 27 bit slots with ACK checks, STOP, bus-free time,
// with automatic resends of NACKed frames. All pin outputs come straight from flops.
module i2c_write_engine
  import codec_cfg_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        eng_go,
  input  logic [23:0] eng_word,
  input  logic        i_sdat,
  output logic        eng_done,
  output logic        o_nack_fatal,
  output logic        o_sclk,
  output logic        o_sdat,
  output logic        o_oen
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int RW = $clog2(MAX_RETRY + 2);

  eng_state_t     st, st_n;
  logic [PW-1:0]  phase, phase_n;
  logic [3:0]     bitpos, bitpos_n;
  logic [1:0]     bytecnt, bytecnt_n;
  logic [23:0]    word, word_n;
  logic [23:0]    sh, sh_n;
  logic [RW-1:0]  retry, retry_n;
  logic           nack, nack_n;
  logic           sclk_n, sdat_n, oen_n;
  logic           phase_last;
  logic           resend;

  assign phase_last   = (phase == PW'(CLK_DIV - 1));
  assign resend       = nack && (retry < RW'(MAX_RETRY));
  assign eng_done     = (st == E_BUF) && phase_last && !resend;
  assign o_nack_fatal = eng_done && nack;

  // Next-state logic: every timed state runs CLK_DIV cycles, bit slots walk the shift register.
  always_comb begin
    st_n      = st;
    phase_n   = phase;
    bitpos_n  = bitpos;
    bytecnt_n = bytecnt;
    word_n    = word;
    sh_n      = sh;
    retry_n   = retry;
    nack_n    = nack;
    if (st != E_IDLE && st != E_LOAD) begin
      phase_n = phase_last ? '0 : phase + 1'b1;
    end
    case (st)
      E_IDLE: begin
        if (eng_go) begin
          st_n    = E_LOAD;
          word_n  = eng_word;
          retry_n = '0;
          nack_n  = 1'b0;
        end
      end
      E_LOAD: begin
        st_n      = E_START;
        phase_n   = '0;
        sh_n      = word;
        bitpos_n  = '0;
        bytecnt_n = '0;
      end
      E_START: begin
        if (phase_last) st_n = E_BIT_LO;
      end
      E_BIT_LO: begin
        if (phase_last) st_n = E_BIT_HI;
      end
      E_BIT_HI: begin
        if (phase_last) begin
          if (bitpos == ACK_SLOT) begin
            if (i_sdat) begin
              st_n   = E_STOP0;
              nack_n = 1'b1;
            end else if (bytecnt == 2'd2) begin
              st_n = E_STOP0;
            end else begin
              st_n      = E_BIT_LO;
              bitpos_n  = '0;
              bytecnt_n = bytecnt + 1'b1;
            end
          end else begin
            st_n     = E_BIT_LO;
            bitpos_n = bitpos + 1'b1;
            sh_n     = {sh[22:0], 1'b0};
          end
        end
      end
      E_STOP0: begin
        if (phase_last) st_n = E_STOP1;
      end
      E_STOP1: begin
        if (phase_last) st_n = E_STOP2;
      end
      E_STOP2: begin
        if (phase_last) st_n = E_BUF;
      end
      E_BUF: begin
        if (phase_last) begin
          if (resend) begin
            st_n      = E_START;
            retry_n   = retry + 1'b1;
            nack_n    = 1'b0;
            sh_n      = word;
            bitpos_n  = '0;
            bytecnt_n = '0;
          end else begin
            st_n = E_IDLE;
          end
        end
      end
      default: st_n = E_IDLE;
    endcase
  end

  // Pin values for the state being entered, so the flops present them from the first cycle.
  always_comb begin
    sclk_n = 1'b1;
    sdat_n = 1'b1;
    oen_n  = 1'b1;
    case (st_n)
      E_START: sdat_n = 1'b0;
      E_BIT_LO, E_BIT_HI: begin
        sclk_n = (st_n == E_BIT_HI);
        if (bitpos_n == ACK_SLOT) oen_n = 1'b0;
        else sdat_n = sh_n[23];
      end
      E_STOP0: begin
        sclk_n = 1'b0;
        sdat_n = 1'b0;
      end
      E_STOP1: sdat_n = 1'b0;
      default: ;
    endcase
  end

  // State and pin registers; reset releases the bus high without a STOP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st      <= E_IDLE;
      phase   <= '0;
      bitpos  <= '0;
      bytecnt <= '0;
      word    <= '0;
      sh      <= '0;
      retry   <= '0;
      nack    <= 1'b0;
      o_sclk  <= 1'b1;
      o_sdat  <= 1'b1;
      o_oen   <= 1'b1;
    end else begin
      st      <= st_n;
      phase   <= phase_n;
      bitpos  <= bitpos_n;
      bytecnt <= bytecnt_n;
      word    <= word_n;
      sh      <= sh_n;
      retry   <= retry_n;
      nack    <= nack_n;
      o_sclk  <= sclk_n;
      o_sdat  <= sdat_n;
      o_oen   <= oen_n;
    end
  end

endmodule

// File: rtl/codec_cfg_scheduler.sv
// Sequences the WM8731 boot word list and then run-time register writes onto one shared
// 2-wire control bus, one frame at a time.
module codec_cfg_scheduler
  import codec_cfg_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter logic [6:0] DEV_ADDR  = WRITE_BYTE[7:1],
  parameter int         N_INIT    = INIT_WORDS,
  parameter int         MAX_RETRY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_req_valid,
  input  logic [15:0] i_req_data,
  output logic        o_req_ready,
  input  logic        i_sdat,
  output logic        o_sclk,
  output logic        o_sdat,
  output logic        o_oen,
  output logic        o_init_done,
  output logic        o_busy,
  output logic        o_err
);

  localparam int         IW        = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b0};

  sched_state_t   st;
  logic [IW-1:0]  idx;
  logic [15:0]    req_word;
  logic [15:0]    payload;
  logic           eng_go;
  logic [23:0]    eng_word;
  logic           eng_done;
  logic           nack_fatal;

  assign o_req_ready = (st == S_IDLE) && o_init_done && !i_start;
  assign o_busy      = (st != S_IDLE);
  assign eng_go      = (st == S_INIT_ISSUE) || (st == S_RUN_ISSUE);
  assign eng_word    = frame_word(ADDR_BYTE, payload);

  // Pick the register word for the frame being issued: boot list entry or latched request.
  always_comb begin
    payload = INIT_ROM[idx];
    if (st == S_RUN_ISSUE) payload = req_word;
  end

  // Scheduler: i_start wins over a same-cycle request and is only honoured while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st          <= S_IDLE;
      idx         <= '0;
      req_word    <= '0;
      o_init_done <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (i_start) begin
            st          <= S_INIT_ISSUE;
            idx         <= '0;
            o_err       <= 1'b0;
            o_init_done <= 1'b0;
          end else if (i_req_valid && o_req_ready) begin
            req_word <= i_req_data;
            st       <= S_RUN_ISSUE;
          end
        end
        S_INIT_ISSUE: st <= S_INIT_WAIT;
        S_INIT_WAIT: begin
          if (eng_done) begin
            if (idx == IW'(N_INIT - 1)) begin
              st          <= S_IDLE;
              o_init_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              st  <= S_INIT_ISSUE;
            end
          end
        end
        S_RUN_ISSUE: st <= S_RUN_WAIT;
        S_RUN_WAIT: begin
          if (eng_done) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
      if (eng_done && nack_fatal) o_err <= 1'b1;
    end
  end

  i2c_write_engine #(
    .CLK_DIV   (CLK_DIV),
    .MAX_RETRY (MAX_RETRY)
  ) u_engine (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .eng_go       (eng_go),
    .eng_word     (eng_word),
    .i_sdat       (i_sdat),
    .eng_done     (eng_done),
    .o_nack_fatal (nack_fatal),
    .o_sclk       (o_sclk),
    .o_sdat       (o_sdat),
    .o_oen        (o_oen)
  );

endmodule

// File: tb/tb_codec_cfg_scheduler.sv
// Self-checking bench for codec_cfg_scheduler: a bus-level codec model decodes frames from the
// pins and answers ACK slots, while the checks compare against words and cycle counts
// derived from the frame format.
module tb_codec_cfg_scheduler;

  localparam int         CLK_DIV       = 4;
  localparam int         N_INIT        = 7;
  localparam int         WORD_CYCLES   = 59 * CLK_DIV + 2;
  localparam int         INIT_CYCLES   = N_INIT * WORD_CYCLES;
  localparam int         NACK_ATTEMPT  = (1 + 18 + 4) * CLK_DIV;
  localparam int         NORMAL_FRAME  = 59 * CLK_DIV;
  localparam int         LOOP_BOUND    = 4000;
  localparam logic [7:0] EXP_ADDR_BYTE = 8'h34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        req_valid;
  logic [15:0] req_data;
  logic        req_ready;
  logic        sdat_in;
  logic        sclk, sdat, oen;
  logic        init_done, busy, err;

  int total = 0;
  int bad   = 0;

  // Boot list as the codec should receive it, {reg_addr, reg_data}.
  logic [15:0] ref_rom [N_INIT] = '{
    {7'h00, 9'h017}, {7'h01, 9'h017}, {7'h04, 9'h012}, {7'h05, 9'h000},
    {7'h06, 9'h000}, {7'h07, 9'h042}, {7'h08, 9'h000}
  };

  typedef struct {
    logic [15:0] req;
    logic [23:0] exp_word;
    int          exp_low;
  } vec_t;

  vec_t vecs [4];

  // Bus-level codec model state.
  int          start_cnt  = 0;
  int          bitcnt     = 0;
  logic [23:0] cur        = '0;
  logic [23:0] frames [$];
  logic        nack_frame = 1'b0;
  int          nack_first = -1;
  int          nack_last  = -2;
  logic        prev_sclk  = 1'b1;
  logic        prev_line  = 1'b1;
  logic        line;

  always #5 clk = ~clk;

  assign line    = oen ? sdat : sdat_in;
  assign sdat_in = oen ? 1'b1 : (nack_frame && bitcnt <= 9);

  codec_cfg_scheduler #(
    .CLK_DIV   (CLK_DIV),
    .DEV_ADDR  (7'h1A),
    .N_INIT    (N_INIT),
    .MAX_RETRY (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_sdat      (sdat_in),
    .o_sclk      (sclk),
    .o_sdat      (sdat),
    .o_oen       (oen),
    .o_init_done (init_done),
    .o_busy      (busy),
    .o_err       (err)
  );

  // Codec model: detects START/STOP on the wire, collects data bits on SCL rise, keeps whole frames.
  always @(negedge clk) begin
    if (sclk && prev_sclk && prev_line && !line) begin
      nack_frame <= (start_cnt >= nack_first) && (start_cnt <= nack_last);
      start_cnt  <= start_cnt + 1;
      bitcnt     <= 0;
    end else if (sclk && prev_sclk && !prev_line && line) begin
      if (bitcnt == 27) frames.push_back(cur);
    end else if (sclk && !prev_sclk && bitcnt < 27) begin
      if (bitcnt % 9 != 8) cur <= {cur[22:0], sdat};
      bitcnt <= bitcnt + 1;
    end
    prev_sclk <= sclk;
    prev_line <= line;
  end

  // Hard stop in case the design hangs somewhere a bounded loop does not cover.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] modelFrame(input logic [15:0] r);
    return {EXP_ADDR_BYTE, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Pulses i_start and counts clock edges until o_init_done rises.
  task automatic runInit(output int cycles, output logic err_after_start, output int ready_seen);
    start = 1'b1;
    tick();
    start           = 1'b0;
    req_valid       = 1'b0;
    err_after_start = err;
    cycles          = 0;
    ready_seen      = 0;
    while (!init_done && cycles < LOOP_BOUND) begin
      if (req_ready) ready_seen++;
      tick();
      cycles++;
    end
  endtask

  // One run-time write: wait for ready, hand over the request, measure the ready-low window.
  task automatic applyStimulus(input logic [15:0] req, output logic [23:0] word, output int low);
    int waited;
    int fsz;
    waited = 0;
    while (!req_ready && waited < LOOP_BOUND) begin
      tick();
      waited++;
    end
    fsz       = frames.size();
    req_valid = 1'b1;
    req_data  = req;
    tick();
    req_valid = 1'b0;
    low       = 0;
    while (!req_ready && low < LOOP_BOUND) begin
      tick();
      low++;
    end
    word = (frames.size() == fsz + 1) ? frames[fsz] : 24'hxxxxxx;
  endtask

  // Compares the frames captured since base with the boot list, leaving out one skipped word.
  task automatic checkInitFrames(input int base, input int skip, input string tag);
    int          n;
    logic [23:0] got;
    n = 0;
    for (int i = 0; i < N_INIT; i++) begin
      if (i != skip) begin
        got = (base + n < frames.size()) ? frames[base + n] : 24'hxxxxxx;
        checkOutput($sformatf("%s_word%0d", tag, i), {8'h00, got},
                    {8'h00, modelFrame(ref_rom[i])});
        n++;
      end
    end
    checkOutput({tag, "_frame_count"}, frames.size() - base, n);
  endtask

  // Main sequence.
  initial begin
    int          cycles;
    int          ready_seen;
    int          low;
    int          fbase;
    int          sbase;
    logic        err0;
    logic [23:0] w;
    logic [15:0] r;

    rst       = 1'b1;
    start     = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;

    vecs[0] = '{16'h0479, 24'h340479, 238};
    vecs[1] = '{16'h0C10, 24'h340C10, 238};
    vecs[2] = '{16'hFFFF, 24'h34FFFF, 238};
    vecs[3] = '{16'h0000, 24'h340000, 238};

    repeat (3) tick();
    checkOutput("rst_sclk", sclk, 1);
    checkOutput("rst_sdat", sdat, 1);
    checkOutput("rst_oen", oen, 1);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    rst = 1'b0;
    tick();

    $display("[TB] boot sequence with every word acknowledged");
    fbase = frames.size();
    sbase = start_cnt;
    runInit(cycles, err0, ready_seen);
    checkOutput("init1_cycles", cycles, INIT_CYCLES);
    checkOutput("init1_ready_during", ready_seen, 0);
    checkOutput("init1_err", err, 0);
    checkOutput("init1_starts", start_cnt - sbase, N_INIT);
    checkOutput("init1_first_byte", (frames.size() > fbase) ? {24'h0, frames[fbase][23:16]} : 32'hx,
                {24'h0, 8'b0011_0100});
    checkInitFrames(fbase, -1, "init1");

    $display("[TB] run-time request table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, w, low);
      checkOutput($sformatf("vec%0d_word", i), {8'h00, w}, {8'h00, vecs[i].exp_word});
      checkOutput($sformatf("vec%0d_ready_low", i), low, vecs[i].exp_low);
    end

    $display("[TB] random run-time requests");
    for (int i = 0; i < 5; i++) begin
      r = 16'($urandom);
      applyStimulus(r, w, low);
      checkOutput($sformatf("rand%0d_word", i), {8'h00, w}, {8'h00, modelFrame(r)});
      checkOutput($sformatf("rand%0d_ready_low", i), low, WORD_CYCLES);
    end
    checkOutput("req_err", err, 0);

    $display("[TB] start and request in the same idle cycle");
    fbase     = frames.size();
    req_valid = 1'b1;
    req_data  = 16'h0ABC;
    runInit(cycles, err0, ready_seen);
    checkOutput("race_cycles", cycles, INIT_CYCLES);
    checkOutput("race_ready_during", ready_seen, 0);
    checkOutput("race_ready_after", req_ready, 1);
    checkInitFrames(fbase, -1, "race");

    $display("[TB] word 2 refused on every attempt");
    fbase      = frames.size();
    sbase      = start_cnt;
    nack_first = start_cnt + 2;
    nack_last  = nack_first + 2;
    runInit(cycles, err0, ready_seen);
    checkOutput("fatal_cycles", cycles, INIT_CYCLES + 3 * NACK_ATTEMPT - NORMAL_FRAME);
    checkOutput("fatal_starts", start_cnt - sbase, N_INIT + 2);
    checkOutput("fatal_err", err, 1);
    checkOutput("fatal_init_done", init_done, 1);
    checkInitFrames(fbase, 2, "fatal");
    nack_first = -1;
    nack_last  = -2;

    $display("[TB] fresh start after a failed word");
    runInit(cycles, err0, ready_seen);
    checkOutput("fresh_err_cleared", err0, 0);
    checkOutput("fresh_cycles", cycles, INIT_CYCLES);
    checkOutput("fresh_err_end", err, 0);

    $display("[TB] single refusal on word 2");
    fbase      = frames.size();
    sbase      = start_cnt;
    nack_first = start_cnt + 2;
    nack_last  = nack_first;
    runInit(cycles, err0, ready_seen);
    checkOutput("retry_cycles", cycles, INIT_CYCLES + NACK_ATTEMPT);
    checkOutput("retry_starts", start_cnt - sbase, N_INIT + 1);
    checkOutput("retry_err", err, 0);
    checkInitFrames(fbase, -1, "retry");
    nack_first = -1;
    nack_last  = -2;

    $display("[TB] reset in the middle of a frame");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_sclk", sclk, 1);
    checkOutput("midrst_sdat", sdat, 1);
    checkOutput("midrst_oen", oen, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_init_done", init_done, 0);
    rst = 1'b0;
    repeat (300) tick();
    checkOutput("midrst_idle_init_done", init_done, 0);
    checkOutput("midrst_idle_busy", busy, 0);
    checkOutput("midrst_idle_ready", req_ready, 0);

    $display("[TB] boot again after the reset");
    fbase = frames.size();
    runInit(cycles, err0, ready_seen);
    checkOutput("recover_cycles", cycles, INIT_CYCLES);
    checkInitFrames(fbase, -1, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
